// File: rtl/result_pkg.sv
// Shared definitions for the result streamer: command codes, frame header,
// FSM state encoding and the decoded command kind.
package result_pkg;

  localparam logic [7:0] CMD_DIGIT_CODE  = 8'hCC;
  localparam logic [7:0] CMD_SCORES_CODE = 8'hCD;
  localparam logic [7:0] CMD_STATUS_CODE = 8'hCE;
  localparam logic [7:0] CMD_FRAME_CODE  = 8'hCF;
  localparam logic [7:0] FRAME_HDR       = 8'hA5;

  // Streaming FSM. The numeric encoding is visible on the dbg_state port.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4
  } state_t;

  // Command kind latched at acceptance; selects the response layout.
  typedef enum logic [1:0] {
    K_DIGIT  = 2'd0,
    K_SCORES = 2'd1,
    K_STATUS = 2'd2,
    K_FRAME  = 2'd3
  } cmd_kind_t;

  // Status byte layout: {seq[3:0], 2'b00, sent_flag, valid_flag}.
  function automatic logic [7:0] status_byte(input logic [7:0] seq,
                                             input logic       sent,
                                             input logic       valid);
    return {seq[3:0], 2'b00, sent, valid};
  endfunction

endpackage

// File: rtl/result_streamer_byte_selector.sv
// byte_selector: maps the current byte index of a response onto the byte
// to transmit, using the frozen tx bank, the snapshot sequence/status and
// the running checksum. Purely combinational.
module byte_selector
  import result_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 32,
  parameter int IDX_W       = 6
) (
  input  logic [IDX_W-1:0]               byte_idx,
  input  cmd_kind_t                      kind,
  input  logic [3:0]                     tx_digit,
  input  logic [NUM_CLASSES*SCORE_W-1:0] tx_scores,
  input  logic [7:0]                     tx_seq,
  input  logic [7:0]                     tx_status,
  input  logic [7:0]                     checksum,
  output logic [7:0]                     byte_out
);

  localparam int NB = NUM_CLASSES * SCORE_W / 8;

  logic [IDX_W-1:0] score_idx;
  logic [7:0]       score_byte;

  // Score bytes are contiguous in the flat vector: class 0 first, LSB first.
  always_comb begin
    score_idx  = (kind == K_FRAME) ? (byte_idx - IDX_W'(3)) : byte_idx;
    score_byte = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (score_idx == IDX_W'(i)) score_byte = tx_scores[i*8 +: 8];
    end
  end

  // Response layout per command kind.
  always_comb begin
    byte_out = 8'h00;
    case (kind)
      K_DIGIT:  byte_out = {4'h0, tx_digit};
      K_SCORES: byte_out = score_byte;
      K_STATUS: byte_out = tx_status;
      K_FRAME: begin
        if (byte_idx == IDX_W'(0))           byte_out = FRAME_HDR;
        else if (byte_idx == IDX_W'(1))      byte_out = tx_seq;
        else if (byte_idx == IDX_W'(2))      byte_out = {4'h0, tx_digit};
        else if (byte_idx == IDX_W'(NB + 3)) byte_out = checksum;
        else                                 byte_out = score_byte;
      end
      default:  byte_out = 8'h00;
    endcase
  end

endmodule

// File: rtl/result_streamer.sv
// result_streamer: holds the latest classifier result and streams it to a
// UART transmitter on command. A live bank follows every result; a tx bank
// is frozen at command acceptance so a response never mixes two results.
//
// Transmit handshake: a byte is offered by pulsing tx_send for one cycle
// while tx_busy is low; the transmitter raises tx_busy to take it and drops
// it when done. tx_data holds from the send cycle until tx_busy falls.
module result_streamer
  import result_pkg::*;
#(
  parameter int         NUM_CLASSES = 10,
  parameter int         SCORE_W     = 32,
  parameter logic [7:0] CMD_DIGIT   = CMD_DIGIT_CODE,
  parameter logic [7:0] CMD_SCORES  = CMD_SCORES_CODE,
  parameter logic [7:0] CMD_STATUS  = CMD_STATUS_CODE,
  parameter logic [7:0] CMD_FRAME   = CMD_FRAME_CODE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           result_done,
  input  logic [3:0]                     predicted_digit,
  input  logic [NUM_CLASSES*SCORE_W-1:0] scores_flat,
  input  logic [7:0]                     cmd_data,
  input  logic                           cmd_ready,
  output logic [7:0]                     tx_data,
  output logic                           tx_send,
  input  logic                           tx_busy,
  output logic                           streaming,
  output logic [7:0]                     result_seq,
  output logic [2:0]                     dbg_state
);

  localparam int NB        = NUM_CLASSES * SCORE_W / 8;
  localparam int FRAME_LEN = NB + 4;
  localparam int IDX_W     = $clog2(FRAME_LEN + 1);
  localparam int FLAT_W    = NUM_CLASSES * SCORE_W;

  state_t             state_q, state_d;
  cmd_kind_t          kind_q, kind_d;
  logic [3:0]         live_digit_q, live_digit_d;
  logic [FLAT_W-1:0]  live_scores_q, live_scores_d;
  logic [3:0]         tx_digit_q, tx_digit_d;
  logic [FLAT_W-1:0]  tx_scores_q, tx_scores_d;
  logic [7:0]         tx_seq_q, tx_seq_d;
  logic [7:0]         tx_status_q, tx_status_d;
  logic [7:0]         seq_q, seq_d;
  logic               valid_q, valid_d;
  logic               sent_q, sent_d;
  logic [7:0]         csum_q, csum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         tx_data_q, tx_data_d;

  logic               cmd_hit;
  cmd_kind_t          cmd_kind;
  logic               accept;
  logic               set_sent;
  logic               send_now;
  logic [IDX_W-1:0]   last_idx;
  logic [7:0]         sel_byte;

  // Command decode; unknown codes never hit.
  always_comb begin
    cmd_hit  = 1'b0;
    cmd_kind = K_DIGIT;
    if (cmd_data == CMD_DIGIT) begin
      cmd_hit  = 1'b1;
      cmd_kind = K_DIGIT;
    end else if (cmd_data == CMD_SCORES) begin
      cmd_hit  = 1'b1;
      cmd_kind = K_SCORES;
    end else if (cmd_data == CMD_STATUS) begin
      cmd_hit  = 1'b1;
      cmd_kind = K_STATUS;
    end else if (cmd_data == CMD_FRAME) begin
      cmd_hit  = 1'b1;
      cmd_kind = K_FRAME;
    end
  end

  // Index of the final byte of the response in flight.
  always_comb begin
    last_idx = '0;
    case (kind_q)
      K_FRAME:  last_idx = IDX_W'(FRAME_LEN - 1);
      K_SCORES: last_idx = IDX_W'(NB - 1);
      default:  last_idx = '0;
    endcase
  end

  assign accept   = (state_q == ST_IDLE) && cmd_ready && cmd_hit;
  // Gated by rst so an abort never lets a final strobe escape.
  assign send_now = (state_q == ST_SEND) && !tx_busy && !rst;

  byte_selector #(
    .NUM_CLASSES (NUM_CLASSES),
    .SCORE_W     (SCORE_W),
    .IDX_W       (IDX_W)
  ) u_byte_selector (
    .byte_idx  (idx_q),
    .kind      (kind_q),
    .tx_digit  (tx_digit_q),
    .tx_scores (tx_scores_q),
    .tx_seq    (tx_seq_q),
    .tx_status (tx_status_q),
    .checksum  (csum_q),
    .byte_out  (sel_byte)
  );

  // Live bank, flags, and the streaming FSM next-state logic.
  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    live_digit_d  = live_digit_q;
    live_scores_d = live_scores_q;
    tx_digit_d    = tx_digit_q;
    tx_scores_d   = tx_scores_q;
    tx_seq_d      = tx_seq_q;
    tx_status_d   = tx_status_q;
    seq_d         = seq_q;
    valid_d       = valid_q;
    csum_d        = csum_q;
    idx_d         = idx_q;
    tx_data_d     = tx_data_q;
    set_sent      = 1'b0;

    if (result_done) begin
      live_digit_d  = predicted_digit;
      live_scores_d = scores_flat;
      seq_d         = seq_q + 8'd1;
      valid_d       = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_LOAD;
          kind_d      = cmd_kind;
          idx_d       = '0;
          csum_d      = 8'h00;
          // Same-cycle result bypasses into the tx bank.
          tx_digit_d  = result_done ? predicted_digit : live_digit_q;
          tx_scores_d = result_done ? scores_flat     : live_scores_q;
          tx_seq_d    = seq_d;
          tx_status_d = status_byte(seq_d, sent_q && !result_done, valid_d);
        end
      end
      ST_LOAD: begin
        tx_data_d = sel_byte;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy) begin
          csum_d  = csum_q ^ tx_data_q;
          state_d = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (tx_busy) state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q == last_idx) begin
            state_d  = ST_IDLE;
            set_sent = (kind_q != K_STATUS);
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new result always wins over a completing response.
    sent_d = result_done ? 1'b0 : (set_sent ? 1'b1 : sent_q);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      kind_q        <= K_DIGIT;
      live_digit_q  <= '0;
      live_scores_q <= '0;
      tx_digit_q    <= '0;
      tx_scores_q   <= '0;
      tx_seq_q      <= '0;
      tx_status_q   <= '0;
      seq_q         <= '0;
      valid_q       <= 1'b0;
      sent_q        <= 1'b0;
      csum_q        <= '0;
      idx_q         <= '0;
      tx_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      live_digit_q  <= live_digit_d;
      live_scores_q <= live_scores_d;
      tx_digit_q    <= tx_digit_d;
      tx_scores_q   <= tx_scores_d;
      tx_seq_q      <= tx_seq_d;
      tx_status_q   <= tx_status_d;
      seq_q         <= seq_d;
      valid_q       <= valid_d;
      sent_q        <= sent_d;
      csum_q        <= csum_d;
      idx_q         <= idx_d;
      tx_data_q     <= tx_data_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_send    = send_now;
  assign streaming  = (state_q != ST_IDLE);
  assign result_seq = seq_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: a small UART model captures every
// transmitted byte, and each response is compared against an expected queue.
module tb_result_streamer;

  localparam int NUM_CLASSES = 10;
  localparam int SCORE_W     = 32;
  localparam int NB          = NUM_CLASSES * SCORE_W / 8;
  localparam int FLAT_W      = NUM_CLASSES * SCORE_W;

  localparam logic [7:0] C_DIGIT  = 8'hCC;
  localparam logic [7:0] C_SCORES = 8'hCD;
  localparam logic [7:0] C_STATUS = 8'hCE;
  localparam logic [7:0] C_FRAME  = 8'hCF;

  logic              clk = 1'b0;
  logic              rst;
  logic              result_done;
  logic [3:0]        predicted_digit;
  logic [FLAT_W-1:0] scores_flat;
  logic [7:0]        cmd_data;
  logic              cmd_ready;
  logic [7:0]        tx_data;
  logic              tx_send;
  logic              tx_busy;
  logic              streaming;
  logic [7:0]        result_seq;
  logic [2:0]        dbg_state;

  logic              busy_model;
  logic              busy_force;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int sends     = 0;
  int bad_sends = 0;
  int snap;

  logic [FLAT_W-1:0] scores_a;
  logic [FLAT_W-1:0] scores_b;

  assign tx_busy = busy_model | busy_force;

  result_streamer #(
    .NUM_CLASSES (NUM_CLASSES),
    .SCORE_W     (SCORE_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .result_done     (result_done),
    .predicted_digit (predicted_digit),
    .scores_flat     (scores_flat),
    .cmd_data        (cmd_data),
    .cmd_ready       (cmd_ready),
    .tx_data         (tx_data),
    .tx_send         (tx_send),
    .tx_busy         (tx_busy),
    .streaming       (streaming),
    .result_seq      (result_seq),
    .dbg_state       (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  // UART model: takes a byte on tx_send, then busy for a few cycles.
  initial begin
    busy_model = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_send) begin
        rx_q.push_back(tx_data);
        @(negedge clk);
        busy_model = 1'b1;
        repeat (3) @(negedge clk);
        busy_model = 1'b0;
      end
    end
  end

  // Strobe monitor: counts sends and any send while busy.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_send) begin
        sends++;
        if (tx_busy) bad_sends++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [FLAT_W-1:0] make_scores(input int pat);
    logic [FLAT_W-1:0] f;
    f = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (pat == 0) f[k*SCORE_W +: SCORE_W] = 32'(k * 256 + k);
      else          f[k*SCORE_W +: SCORE_W] = 32'hFFFF_FFFF - 32'(k);
    end
    return f;
  endfunction

  task automatic push_scores(input logic [FLAT_W-1:0] f);
    for (int n = 0; n < NB; n++) exp_q.push_back(f[n*8 +: 8]);
  endtask

  task automatic push_frame(input logic [7:0] seq, input logic [3:0] dig,
                            input logic [FLAT_W-1:0] f);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'hA5;
    exp_q.push_back(8'hA5);
    x = x ^ seq;
    exp_q.push_back(seq);
    b = {4'h0, dig};
    x = x ^ b;
    exp_q.push_back(b);
    for (int n = 0; n < NB; n++) begin
      b = f[n*8 +: 8];
      x = x ^ b;
      exp_q.push_back(b);
    end
    exp_q.push_back(x);
  endtask

  // Driver tasks: all called at a negedge, return at a negedge.
  task automatic pulse_result(input logic [3:0] dig, input logic [FLAT_W-1:0] f);
    result_done     = 1'b1;
    predicted_digit = dig;
    scores_flat     = f;
    @(negedge clk);
    result_done = 1'b0;
  endtask

  task automatic issue_cmd(input logic [7:0] code, input bit chk_lat);
    cmd_data  = code;
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    cmd_data  = 8'h00;
    if (chk_lat) begin
      check("accept_streaming", 32'(streaming), 32'd1);
      check("lat_cycle1_nosend", 32'(tx_send), 32'd0);
      @(negedge clk);
      check("lat_cycle2_send", 32'(tx_send), 32'd1);
    end
  endtask

  task automatic wait_rx(input int n);
    int cnt = 0;
    while (rx_q.size() < n && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    check("wait_rx_timeout", 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle();
    int cnt = 0;
    while (streaming && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    check("wait_idle_timeout", 32'(streaming), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Scoreboard: drain received bytes against the expected queue.
  task automatic compare_rx(input string tag);
    int n;
    check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s[%0d]", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  // Main sequence
  initial begin
    rst             = 1'b1;
    result_done     = 1'b0;
    predicted_digit = 4'h0;
    scores_flat     = '0;
    cmd_data        = 8'h00;
    cmd_ready       = 1'b0;
    busy_force      = 1'b0;
    scores_a        = make_scores(0);
    scores_b        = make_scores(1);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_tx_send", 32'(tx_send), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_streaming", 32'(streaming), 32'd0);
    check("rst_result_seq", 32'(result_seq), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // No result yet: status is all zero.
    exp_q.push_back(8'h00);
    issue_cmd(C_STATUS, 1'b1);
    wait_idle();
    compare_rx("status_empty");

    // First result: digit 7, scores k*256+k.
    pulse_result(4'd7, scores_a);
    check("seq_after_1", 32'(result_seq), 32'd1);

    exp_q.push_back(8'h07);
    issue_cmd(C_DIGIT, 1'b1);
    wait_idle();
    compare_rx("digit7");

    issue_cmd(C_SCORES, 1'b1);
    wait_idle();
    check("scores_b0", 32'(rx_q[0]), 32'h00);
    check("scores_b4", 32'(rx_q[4]), 32'h01);
    check("scores_b5", 32'(rx_q[5]), 32'h01);
    check("scores_b6", 32'(rx_q[6]), 32'h00);
    push_scores(scores_a);
    compare_rx("scores_a");

    issue_cmd(C_FRAME, 1'b1);
    wait_idle();
    check("frame_hdr", 32'(rx_q[0]), 32'hA5);
    check("frame_seq", 32'(rx_q[1]), 32'h01);
    check("frame_digit", 32'(rx_q[2]), 32'h07);
    check("frame_csum", 32'(rx_q[NB+3]), 32'hA3);
    push_frame(8'h01, 4'd7, scores_a);
    compare_rx("frame_a");

    exp_q.push_back(8'h13);
    issue_cmd(C_STATUS, 1'b1);
    wait_idle();
    compare_rx("status_13");

    // New result arrives mid-frame: frame keeps the old snapshot.
    push_frame(8'h01, 4'd7, scores_a);
    issue_cmd(C_FRAME, 1'b1);
    wait_rx(10);
    pulse_result(4'd3, scores_b);
    wait_idle();
    compare_rx("frame_frozen");
    check("seq_after_2", 32'(result_seq), 32'd2);

    push_scores(scores_b);
    issue_cmd(C_SCORES, 1'b1);
    wait_idle();
    compare_rx("scores_b");

    exp_q.push_back(8'h23);
    issue_cmd(C_STATUS, 1'b1);
    wait_idle();
    compare_rx("status_23");

    // Third result clears sent_flag.
    pulse_result(4'd9, scores_b);
    exp_q.push_back(8'h31);
    issue_cmd(C_STATUS, 1'b1);
    wait_idle();
    compare_rx("status_31");

    // Command while streaming is ignored.
    push_frame(8'h03, 4'd9, scores_b);
    issue_cmd(C_FRAME, 1'b1);
    wait_rx(3);
    issue_cmd(C_DIGIT, 1'b0);
    wait_idle();
    compare_rx("frame_ignore_cmd");

    // Unknown code in IDLE is ignored.
    snap = sends;
    issue_cmd(8'h00, 1'b0);
    check("unknown_no_stream", 32'(streaming), 32'd0);
    repeat (20) @(negedge clk);
    check("unknown_no_send", 32'(sends), 32'(snap));
    check("unknown_no_rx", 32'(rx_q.size()), 32'd0);

    // Transmitter stuck busy: no further strobes until it frees up.
    push_scores(scores_b);
    issue_cmd(C_SCORES, 1'b1);
    wait_rx(1);
    @(negedge clk);
    busy_force = 1'b1;
    snap = sends;
    repeat (1000) @(negedge clk);
    check("busy_hold_no_send", 32'(sends), 32'(snap));
    check("busy_hold_streaming", 32'(streaming), 32'd1);
    busy_force = 1'b0;
    wait_idle();
    compare_rx("scores_after_busy");

    // Reset after the 5th frame byte aborts the stream.
    issue_cmd(C_FRAME, 1'b1);
    wait_rx(5);
    @(negedge clk);
    rst  = 1'b1;
    snap = sends;
    for (int i = 0; i < 3; i++) begin
      check("rst_mid_no_send", 32'(tx_send), 32'd0);
      @(negedge clk);
    end
    rst = 1'b0;
    check("rst_mid_tx_data", 32'(tx_data), 32'h00);
    check("rst_mid_streaming", 32'(streaming), 32'd0);
    check("rst_mid_seq", 32'(result_seq), 32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'd0);
    repeat (100) @(negedge clk);
    check("rst_mid_sends", 32'(sends), 32'(snap));
    rx_q.delete();
    exp_q.delete();

    exp_q.push_back(8'h00);
    issue_cmd(C_STATUS, 1'b1);
    wait_idle();
    compare_rx("status_after_rst");

    check("send_while_busy", 32'(bad_sends), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
